sipo_deserializer: RTL

//   Serial-in/parallel-out front end for the 3-bit parallel register stage.
//   - Collects MSB-first serial bits into a WIDTH-bit word.
//   - Presents each word on q with a valid/ready handshake.
//   - Holds one completed word while the next one is shifting in.
//   - Sets a sticky overflow flag when a completed word cannot be delivered.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_bit_counter.sv | 28 ++
 rtl/sipo_deserializer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } sipo_state_t;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit position counter for one serial frame; load1 wins over clr, clr over inc.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  input  logic                     load1,
  output logic [cnt_w(WIDTH)-1:0]  cnt,
  output logic                     last
);

  localparam int CW = cnt_w(WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (load1) cnt <= CW'(1);
    else if (clr)   cnt <= '0;
    else if (inc)   cnt <= cnt + CW'(1);
  end

  // Combinational so the top can deliver on the same edge that takes the final data bit.
  assign last = inc && (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with one-word output holding register.
// Define SIPO_PARITY_EN to append an even-parity bit to each frame and report parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CW = cnt_w(WIDTH);

  sipo_state_t      state, nstate;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             sr_load, sr_shift;
  logic             cnt_inc, cnt_clr, cnt_load1;
  logic             done;
  logic             accept;

  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // sin_start always resyncs, whatever the current state.
  always_comb begin
    nstate = state;
    if (sin_valid) begin
      if (sin_start) begin
        nstate = DATA;
      end else begin
        case (state)
          DATA: begin
`ifdef SIPO_PARITY_EN
            if (cnt_last) nstate = PARITY;
`else
            if (cnt_last) nstate = IDLE;
`endif
          end
          PARITY:  nstate = IDLE;
          default: nstate = state;
        endcase
      end
    end
  end

  always_comb begin
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    done      = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        sr_load   = 1'b1;
        cnt_load1 = 1'b1;
      end else begin
        case (state)
          DATA: begin
            sr_shift = 1'b1;
            cnt_inc  = 1'b1;
`ifndef SIPO_PARITY_EN
            done     = cnt_last;
            cnt_clr  = cnt_last;
`endif
          end
`ifdef SIPO_PARITY_EN
          PARITY: begin
            done    = 1'b1;
            cnt_clr = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sr <= '0;
    else if (sr_load)  sr <= {{(WIDTH-1){1'b0}}, sin};
    else if (sr_shift) sr <= {sr[WIDTH-2:0], sin};
  end

`ifdef SIPO_PARITY_EN
  // Word is already complete in sr; sin is the parity bit.
  assign word = sr;
`else
  assign word = {sr[WIDTH-2:0], sin};
`endif

  assign accept = !q_valid || q_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      q_valid  <= 1'b0;
      overflow <= 1'b0;
    end else if (done) begin
      if (accept) begin
        q       <= word;
        q_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 parity_err <= 1'b0;
    else if (done && accept)  parity_err <= (^sr) ^ sin;
  end
`else
  assign parity_err = 1'b0;
`endif

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst) cnt <= CW'(WIDTH));

endmodule
